edge_event_collector: RTL and testbench



---
 rtl/detector_pkg.sv | 29 ++
 rtl/edge_event_fifo.sv | 56 +++++
 rtl/edge_event_collector.sv | 184 ++++++++++++++++++
 tb/tb_edge_event_collector.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_pkg.sv
// Shared constants, event type and helpers for the edge detector pipeline.
package detector_pkg;

  localparam int PixelHeight  = 5;
  localparam int RowWidth     = (PixelHeight > 1) ? $clog2(PixelHeight) : 1;
  localparam int TsWidth      = 16;
  localparam int ConfirmCount = 3;
  localparam int ReleaseCount = 2;
  localparam int FifoDepth    = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    ACTIVE = 1'b1
  } row_state_t;

  typedef struct packed {
    logic [RowWidth-1:0] row;
    logic [TsWidth-1:0]  timeStamp;
  } edge_event_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [RowWidth-1:0] lowestIndex(input logic [PixelHeight-1:0] vec);
    lowestIndex = '0;
    for (int i = PixelHeight - 1; i >= 0; i--) begin
      if (vec[i]) lowestIndex = RowWidth'(i);
    end
  endfunction

endpackage

// File: rtl/edge_event_fifo.sv
// First-word-fall-through synchronous FIFO of edge events; the head reads as 0 when empty.
module edge_event_fifo
  import detector_pkg::*;
#(
  parameter int  DEPTH   = FifoDepth,
  parameter type entry_t = edge_event_t,
  localparam int PtrWidth   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CountWidth = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  entry_t                pushData,
  output entry_t                headData,
  output logic                  full,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  entry_t              mem [DEPTH];
  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth-1:0] rdPtr;
  logic                doPush;
  logic                doPop;

  always_comb begin
    empty    = (count == '0);
    full     = (count == CountWidth'(DEPTH));
    doPop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    doPush   = push && (!full || doPop);
    headData = empty ? '0 : mem[rdPtr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/edge_event_collector.sv
// Per-row debounce, timestamping and queueing of confirmed edges.
// Build option EDGE_EVENT_STATS_EN adds dropCount and maxFifoCount outputs.
module edge_event_collector
  import detector_pkg::*;
#(
  parameter int  CONFIRM_COUNT = ConfirmCount,
  parameter int  RELEASE_COUNT = ReleaseCount,
  parameter int  FIFO_DEPTH    = FifoDepth,
  parameter int  TS_WIDTH      = TsWidth,
  localparam int CountWidth    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  resultIn [PixelHeight],
  output logic                  eventValid,
  input  logic                  eventReady,
  output logic [RowWidth-1:0]   eventRow,
  output logic [TS_WIDTH-1:0]   eventTime,
  output logic [CountWidth-1:0] fifoCount,
  output logic                  overflow,
`ifdef EDGE_EVENT_STATS_EN
  output logic [15:0]           dropCount,
  output logic [CountWidth-1:0] maxFifoCount,
`endif
  output logic [PixelHeight-1:0] rowActive
);

  // Event handshake: the head entry transfers on a clock edge where eventValid
  // and eventReady are both high; eventValid never waits on eventReady.

  localparam int DropWidth = $clog2(PixelHeight + 1);

  typedef struct packed {
    logic [RowWidth-1:0] row;
    logic [TS_WIDTH-1:0] timeStamp;
  } event_t;

  row_state_t          rowState     [PixelHeight];
  row_state_t          rowStateNext [PixelHeight];
  logic [3:0]          hitCnt       [PixelHeight];
  logic [3:0]          hitCntNext   [PixelHeight];
  logic [3:0]          missCnt      [PixelHeight];
  logic [3:0]          missCntNext  [PixelHeight];
  logic [TS_WIDTH-1:0] rowTs        [PixelHeight];
  logic [TS_WIDTH-1:0] rowTsNext    [PixelHeight];

  logic [PixelHeight-1:0] pending;
  logic [PixelHeight-1:0] pendingNext;
  logic [PixelHeight-1:0] confirm;
  logic [PixelHeight-1:0] drop;
  logic [PixelHeight-1:0] pushMask;
  logic [DropWidth-1:0]   dropNum;
  logic [TS_WIDTH-1:0]    tsCounter;
  logic [RowWidth-1:0]    grantRow;
  logic                   anyPending;
  logic                   pushEn;
  logic                   popEn;
  logic                   fifoFull;
  logic                   fifoEmpty;
  event_t                 pushEntry;
  event_t                 headEntry;

  // Fixed-priority arbiter: the lowest pending row wins the single push slot.
  always_comb begin
    anyPending = |pending;
    grantRow   = lowestIndex(pending);
    popEn      = eventValid && eventReady;
    pushEn     = anyPending && (!fifoFull || popEn);
    pushMask   = '0;
    if (pushEn) pushMask[grantRow] = 1'b1;
    pushEntry.row       = grantRow;
    pushEntry.timeStamp = rowTs[grantRow];
  end

  always_comb begin
    for (int r = 0; r < PixelHeight; r++) begin
      rowStateNext[r] = rowState[r];
      hitCntNext[r]   = hitCnt[r];
      missCntNext[r]  = missCnt[r];
      confirm[r]      = 1'b0;
      case (rowState[r])
        SEARCH: begin
          if (resultIn[r]) begin
            if (hitCnt[r] == 4'(CONFIRM_COUNT - 1)) begin
              rowStateNext[r] = ACTIVE;
              hitCntNext[r]   = '0;
              confirm[r]      = 1'b1;
            end else begin
              hitCntNext[r] = hitCnt[r] + 4'd1;
            end
          end else begin
            hitCntNext[r] = '0;
          end
        end
        ACTIVE: begin
          if (!resultIn[r]) begin
            if (missCnt[r] == 4'(RELEASE_COUNT - 1)) begin
              rowStateNext[r] = SEARCH;
              missCntNext[r]  = '0;
            end else begin
              missCntNext[r] = missCnt[r] + 4'd1;
            end
          end else begin
            missCntNext[r] = '0;
          end
        end
        default: rowStateNext[r] = SEARCH;
      endcase

      // A row whose pending event leaves this cycle can take a new one without loss.
      drop[r]        = confirm[r] && pending[r] && !pushMask[r];
      pendingNext[r] = confirm[r] || (pending[r] && !pushMask[r]);
      rowTsNext[r]   = (confirm[r] && !drop[r]) ? tsCounter : rowTs[r];
      rowActive[r]   = (rowState[r] == ACTIVE);
    end
  end

  always_comb begin
    dropNum = '0;
    for (int r = 0; r < PixelHeight; r++) begin
      dropNum = dropNum + DropWidth'(drop[r]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < PixelHeight; r++) begin
        rowState[r] <= SEARCH;
        hitCnt[r]   <= '0;
        missCnt[r]  <= '0;
        rowTs[r]    <= '0;
      end
      pending   <= '0;
      tsCounter <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int r = 0; r < PixelHeight; r++) begin
        rowState[r] <= rowStateNext[r];
        hitCnt[r]   <= hitCntNext[r];
        missCnt[r]  <= missCntNext[r];
        rowTs[r]    <= rowTsNext[r];
      end
      pending   <= pendingNext;
      tsCounter <= tsCounter + 1'b1;
      if (|drop) overflow <= 1'b1;
    end
  end

  edge_event_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (event_t)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (pushEn),
    .pop      (popEn),
    .pushData (pushEntry),
    .headData (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign eventValid = !fifoEmpty;
  assign eventRow   = headEntry.row;
  assign eventTime  = headEntry.timeStamp;

`ifdef EDGE_EVENT_STATS_EN
  logic [16:0] dropSum;

  assign dropSum = {1'b0, dropCount} + 17'(dropNum);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dropCount    <= '0;
      maxFifoCount <= '0;
    end else begin
      dropCount <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      if (fifoCount > maxFifoCount) maxFifoCount <= fifoCount;
    end
  end
`endif

endmodule

// File: tb/tb_edge_event_collector.sv
// Directed-plus-random bench for edge_event_collector against a behavioural event model.
module tb_edge_event_collector;
  import detector_pkg::*;

  localparam int TW      = 16;
  localparam int CW      = $clog2(FifoDepth) + 1;
  localparam int EW      = RowWidth + TW;
  localparam int CONFIRM = ConfirmCount;
  localparam int RELEASE = ReleaseCount;
  localparam int DEPTH   = FifoDepth;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                   reset_n;
  logic                   resultIn [PixelHeight];
  logic                   eventValid;
  logic                   eventReady;
  logic [RowWidth-1:0]    eventRow;
  logic [TW-1:0]          eventTime;
  logic [CW-1:0]          fifoCount;
  logic                   overflow;
  logic [PixelHeight-1:0] rowActive;
`ifdef EDGE_EVENT_STATS_EN
  logic [15:0]            dropCount;
  logic [CW-1:0]          maxFifoCount;
`endif

  edge_event_collector dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .resultIn     (resultIn),
    .eventValid   (eventValid),
    .eventReady   (eventReady),
    .eventRow     (eventRow),
    .eventTime    (eventTime),
    .fifoCount    (fifoCount),
    .overflow     (overflow),
`ifdef EDGE_EVENT_STATS_EN
    .dropCount    (dropCount),
    .maxFifoCount (maxFifoCount),
`endif
    .rowActive    (rowActive)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Each row is either armed (looking for a run of CONFIRM ones) or active
  // (looking for a run of RELEASE zeros); mRun is the length of that run.
  logic [EW-1:0] exp_q[$];
  bit            mActive [PixelHeight];
  int            mRun    [PixelHeight];
  bit            mPend   [PixelHeight];
  logic [TW-1:0] mTs     [PixelHeight];
  logic [TW-1:0] mTime;
  bit            mOverflow;
  int            mDrops;
  int            mMax;

  task automatic model_reset();
    exp_q.delete();
    for (int r = 0; r < PixelHeight; r++) begin
      mActive[r] = 0;
      mRun[r]    = 0;
      mPend[r]   = 0;
      mTs[r]     = '0;
    end
    mTime     = '0;
    mOverflow = 0;
    mDrops    = 0;
    mMax      = 0;
  endtask

  task automatic model_edge();
    bit            popNow;
    bit            pushNow;
    int            grant;
    logic [EW-1:0] entry;
    if (exp_q.size() > mMax) mMax = exp_q.size();
    popNow = (exp_q.size() > 0) && eventReady;
    grant  = -1;
    for (int r = 0; r < PixelHeight; r++) begin
      if (mPend[r] && grant < 0) grant = r;
    end
    pushNow = (grant >= 0) && ((exp_q.size() < DEPTH) || popNow);
    entry   = '0;
    if (pushNow) begin
      entry        = {RowWidth'(grant), mTs[grant]};
      mPend[grant] = 0;
    end
    for (int r = 0; r < PixelHeight; r++) begin
      if (!mActive[r]) begin
        mRun[r] = resultIn[r] ? mRun[r] + 1 : 0;
        if (mRun[r] == CONFIRM) begin
          mActive[r] = 1;
          mRun[r]    = 0;
          if (mPend[r]) begin
            mOverflow = 1;
            mDrops++;
          end else begin
            mPend[r] = 1;
            mTs[r]   = mTime;
          end
        end
      end else begin
        mRun[r] = resultIn[r] ? 0 : mRun[r] + 1;
        if (mRun[r] == RELEASE) begin
          mActive[r] = 0;
          mRun[r]    = 0;
        end
      end
    end
    if (popNow)  void'(exp_q.pop_front());
    if (pushNow) exp_q.push_back(entry);
    mTime = mTime + 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [EW-1:0]          head;
    logic [PixelHeight-1:0] expAct;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int r = 0; r < PixelHeight; r++) expAct[r] = mActive[r];
    check("eventValid", 32'(eventValid), 32'(exp_q.size() > 0));
    check("eventRow",   32'(eventRow),   32'(head[EW-1:TW]));
    check("eventTime",  32'(eventTime),  32'(head[TW-1:0]));
    check("fifoCount",  32'(fifoCount),  32'(exp_q.size()));
    check("overflow",   32'(overflow),   32'(mOverflow));
    check("rowActive",  32'(rowActive),  32'(expAct));
`ifdef EDGE_EVENT_STATS_EN
    check("dropCount",    32'(dropCount),    (mDrops > 32'hFFFF) ? 32'hFFFF : 32'(mDrops));
    check("maxFifoCount", 32'(maxFifoCount), 32'(mMax));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [PixelHeight-1:0] v, input logic rdy);
    for (int r = 0; r < PixelHeight; r++) resultIn[r] = v[r];
    eventReady = rdy;
  endtask

  task automatic tick(input logic [PixelHeight-1:0] v, input logic rdy);
    drive(v, rdy);
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_fifoCount",  32'(fifoCount),  32'd0);
    check("rst_eventValid", 32'(eventValid), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [TW-1:0] tExp;
  logic [PixelHeight-1:0] rv;

  initial begin
    reset_n = 1'b0;
    drive('0, 1'b0);
    model_reset();
    #2;
    compare_all();
    check("init_eventRow",  32'(eventRow),  32'd0);
    check("init_eventTime", 32'(eventTime), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Row 2 confirms on its third 1 (timestamp 2), event visible one edge later.
    tick(5'b00100, 1'b0);
    tick(5'b00100, 1'b0);
    tick(5'b00100, 1'b0);
    check("row2_active", 32'(rowActive[2]), 32'd1);
    tick(5'b00000, 1'b0);
    check("row2_valid", 32'(eventValid), 32'd1);
    check("row2_row",   32'(eventRow),   32'd2);
    check("row2_time",  32'(eventTime),  32'd2);
    check("row2_count", 32'(fifoCount),  32'd1);
    for (int i = 0; i < 3; i++) tick('0, 1'b1);

    // Row 0: broken run then a full run -> one event; re-arm; chatter while active.
    tick(5'b00001, 1'b0);
    tick(5'b00001, 1'b0);
    tick(5'b00000, 1'b0);
    tick(5'b00001, 1'b0);
    tick(5'b00001, 1'b0);
    tExp = mTime;
    tick(5'b00001, 1'b0);
    tick(5'b00000, 1'b0);
    check("row0_count1", 32'(fifoCount), 32'd1);
    check("row0_row",    32'(eventRow),  32'd0);
    check("row0_time",   32'(eventTime), 32'(tExp));
    tick(5'b00000, 1'b0);
    tick(5'b00001, 1'b0);
    tick(5'b00001, 1'b0);
    tick(5'b00001, 1'b0);
    tick(5'b00000, 1'b0);
    check("row0_count2", 32'(fifoCount), 32'd2);
    tick(5'b00001, 1'b0);
    tick(5'b00000, 1'b0);
    tick(5'b00001, 1'b0);
    check("row0_chatter_count",  32'(fifoCount),    32'd2);
    check("row0_chatter_active", 32'(rowActive[0]), 32'd1);
    for (int i = 0; i < 4; i++) tick('0, 1'b1);

    // All rows confirm together -> five events in row order with one timestamp.
    tick(5'b11111, 1'b0);
    tick(5'b11111, 1'b0);
    tExp = mTime;
    tick(5'b11111, 1'b0);
    for (int i = 0; i < 5; i++) tick('0, 1'b0);
    check("burst_count", 32'(fifoCount), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("burst_row",  32'(eventRow),  32'(i));
      check("burst_time", 32'(eventTime), 32'(tExp));
      tick('0, 1'b1);
    end

    // Backpressure: 15 confirmations into an 8-deep FIFO, rows 3 and 4 drop once.
    for (int k = 0; k < 3; k++) begin
      tick(5'b11111, 1'b0);
      tick(5'b11111, 1'b0);
      tick(5'b11111, 1'b0);
      tick(5'b00000, 1'b0);
      tick(5'b00000, 1'b0);
    end
    check("bp_count",    32'(fifoCount), 32'd8);
    check("bp_overflow", 32'(overflow),  32'd1);
`ifdef EDGE_EVENT_STATS_EN
    check("bp_drops",    32'(dropCount),    32'd2);
    check("bp_max",      32'(maxFifoCount), 32'd8);
`endif
    // Full FIFO with a pending row: pop and push in the same cycle.
    tick('0, 1'b1);
    check("full_poppush_count", 32'(fifoCount), 32'd8);
    for (int i = 0; i < 12; i++) tick('0, 1'b1);

    // Random traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < PixelHeight; r++) rv[r] = ($urandom_range(0, 3) != 0);
      tick(rv, 1'(($urandom_range(0, 2) != 0)));
    end
    for (int i = 0; i < 16; i++) tick('0, 1'b1);

    // Reset in the middle of a burst with five queued events.
    tick(5'b11111, 1'b0);
    tick(5'b11111, 1'b0);
    tick(5'b11111, 1'b0);
    for (int i = 0; i < 5; i++) tick('0, 1'b0);
    check("midrst_count_before", 32'(fifoCount), 32'd5);
    async_reset();
    tick(5'b00010, 1'b0);
    tick(5'b00010, 1'b0);
    tick(5'b00010, 1'b0);
    tick(5'b00000, 1'b0);
    check("midrst_ts_restart", 32'(eventTime), 32'd2);
    check("midrst_row",        32'(eventRow),  32'd1);
    for (int i = 0; i < 3; i++) tick('0, 1'b1);

    // Timestamp wrap: events confirmed at 16'hFFFF and just after the wrap.
    while (mTime != 16'hFFFD) tick('0, 1'b1);
    tick(5'b00010, 1'b1);
    tick(5'b00010, 1'b1);
    tick(5'b00010, 1'b1);
    tick(5'b01000, 1'b1);
    check("wrap_row1",  32'(eventRow),  32'd1);
    check("wrap_time1", 32'(eventTime), 32'hFFFF);
    tick(5'b01000, 1'b1);
    tick(5'b01000, 1'b1);
    tick(5'b00000, 1'b1);
    check("wrap_row3",  32'(eventRow),  32'd3);
    check("wrap_time3", 32'(eventTime), 32'd2);
    for (int i = 0; i < 4; i++) tick('0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
